// File: rtl/if_id_instr_queue_if.sv
// IF->ID instruction queue handshake bundle.
// slave = the queue itself, master = the IF/ID side driving it.
interface if_id_instr_queue_if #(
   parameter int EXC_W = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      in_instr;
   logic [31:0]      in_pc;
   logic [EXC_W-1:0] in_exc;
   logic             out_valid;
   logic             out_ready;
   logic [31:0]      out_instr;
   logic [15:0]      out_imm16;
   logic [4:0]       out_rs;
   logic [4:0]       out_rt;
   logic [4:0]       out_rd;
   logic [31:0]      out_pc;
   logic [EXC_W-1:0] out_exc;

   modport slave (
      input  in_valid, in_instr, in_pc, in_exc, out_ready,
      output in_ready, out_valid, out_instr, out_imm16,
             out_rs, out_rt, out_rd, out_pc, out_exc
   );

   modport master (
      output in_valid, in_instr, in_pc, in_exc, out_ready,
      input  in_ready, out_valid, out_instr, out_imm16,
             out_rs, out_rt, out_rd, out_pc, out_exc
   );
endinterface

// File: rtl/if_id_instr_queue.sv
// DEPTH-entry IF->ID instruction FIFO with valid/ready on both sides.
// Empty queue presents an all-zero NOP bubble; flush empties it in one cycle.
module if_id_instr_queue #(
   parameter int DEPTH = 4,
   parameter int EXC_W = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   if_id_instr_queue_if.slave     bus,
   output logic [$clog2(DEPTH):0] count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [31:0]      instr_mem_q [DEPTH];
   logic [31:0]      pc_mem_q    [DEPTH];
   logic [EXC_W-1:0] exc_mem_q   [DEPTH];
   logic             enq, deq, out_valid;
   logic [31:0]      head_instr;

   // Handshake qualifiers; in_ready comes only from registered occupancy
   always_comb begin
      bus.in_ready = (count_q != FULL);
      out_valid    = (count_q != '0);
      enq          = bus.in_valid && bus.in_ready && !flush;
      deq          = out_valid && bus.out_ready && !flush;
   end

   // Next-state pointers and occupancy, flush overriding enq/deq
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (enq) wr_ptr_d = wr_ptr_q + AW'(1);
         if (deq) rd_ptr_d = rd_ptr_q + AW'(1);
         if (enq && !deq)
            count_d = count_q + CW'(1);
         else if (deq && !enq)
            count_d = count_q - CW'(1);
      end
   end

   // Control state registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage, written at the tail on enqueue; contents need no reset
   always_ff @(posedge clk) begin
      if (enq && !rst) begin
         instr_mem_q[wr_ptr_q] <= bus.in_instr;
         pc_mem_q[wr_ptr_q]    <= bus.in_pc;
         exc_mem_q[wr_ptr_q]   <= bus.in_exc;
      end
   end

   // Head entry towards ID, zeroed into a bubble when empty
   always_comb begin
      head_instr    = out_valid ? instr_mem_q[rd_ptr_q] : '0;
      bus.out_valid = out_valid;
      bus.out_instr = head_instr;
      bus.out_imm16 = head_instr[15:0];
      bus.out_rs    = head_instr[25:21];
      bus.out_rt    = head_instr[20:16];
      bus.out_rd    = head_instr[15:11];
      bus.out_pc    = out_valid ? pc_mem_q[rd_ptr_q] : '0;
      bus.out_exc   = out_valid ? exc_mem_q[rd_ptr_q] : '0;
      count         = count_q;
   end

   // Occupancy must never leave 0..DEPTH
   always @(posedge clk) begin
      if (!rst) begin
         assert (!(enq && !deq && count_q == FULL))
            else $error("queue overflow");
         assert (!(deq && !enq && count_q == '0))
            else $error("queue underflow");
      end
   end
endmodule

// File: tb/tb_if_id_instr_queue.sv
// Bench for if_id_instr_queue: directed cases plus random traffic,
// checked against a queue-based reference model via a scoreboard.
module tb_if_id_instr_queue;
   localparam int DEPTH = 4;
   localparam int EXC_W = 16;
   localparam int CW    = $clog2(DEPTH) + 1;

   typedef struct packed {
      logic [31:0]      instr;
      logic [31:0]      pc;
      logic [EXC_W-1:0] exc;
   } ent_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          flush;
   logic [CW-1:0] count;

   if_id_instr_queue_if #(.EXC_W(EXC_W)) bus ();

   if_id_instr_queue #(.DEPTH(DEPTH), .EXC_W(EXC_W)) dut (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .bus   (bus),
      .count (count)
   );

   always #5 clk = ~clk;

   ent_t sb[$];
   int   compared   = 0;
   int   mismatched = 0;
   bit   started    = 0;

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Monitor: compare head at mid-cycle, retire it on the next edge
   initial begin
      bit   pop;
      ent_t e;
      forever begin
         @(negedge clk);
         pop = 1'b0;
         if (started) begin
            e = (sb.size() != 0) ? sb[0] : '0;
            chk("out_valid", 64'(bus.out_valid), 64'(sb.size() != 0));
            chk("in_ready", 64'(bus.in_ready), 64'(sb.size() != DEPTH));
            chk("count", 64'(count), 64'(sb.size()));
            chk("out_instr", 64'(bus.out_instr), 64'(e.instr));
            chk("out_pc", 64'(bus.out_pc), 64'(e.pc));
            chk("out_exc", 64'(bus.out_exc), 64'(e.exc));
            chk("out_imm16", 64'(bus.out_imm16), 64'(e.instr[15:0]));
            chk("out_rs", 64'(bus.out_rs), 64'(e.instr[25:21]));
            chk("out_rt", 64'(bus.out_rt), 64'(e.instr[20:16]));
            chk("out_rd", 64'(bus.out_rd), 64'(e.instr[15:11]));
            pop = (sb.size() != 0) && bus.out_ready && !flush && !rst;
         end
         @(posedge clk);
         if (pop) void'(sb.pop_front());
      end
   end

   // One cycle of stimulus; entered and left at posedge+1
   task automatic step(bit v, logic [31:0] i, logic [31:0] p,
                       logic [EXC_W-1:0] x, bit rdy, bit fl, bit r = 1'b0);
      bit acc;
      bit clr;
      rst          = r;
      flush        = fl;
      bus.in_valid = v;
      bus.in_instr = i;
      bus.in_pc    = p;
      bus.in_exc   = x;
      bus.out_ready = rdy;
      @(negedge clk);
      acc = v && !fl && !r && (sb.size() != DEPTH);
      clr = fl || r;
      @(posedge clk);
      if (clr) sb.delete();
      else if (acc) sb.push_back('{instr: i, pc: p, exc: x});
      if (r) started = 1'b1;
      #1;
   endtask

   task automatic idle(bit rdy);
      step(1'b0, 32'h0, 32'h0, '0, rdy, 1'b0);
   endtask

   initial begin
      logic [31:0] pc;
      rst = 1'b1;
      flush = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_instr = '0;
      bus.in_pc = '0;
      bus.in_exc = '0;
      bus.out_ready = 1'b0;
      @(posedge clk);
      #1;
      // reset, idle
      step(1'b0, 32'h0, 32'h0, '0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 32'h0, 32'h0, '0, 1'b0, 1'b0, 1'b1);
      idle(1'b0);
      // single pass
      step(1'b1, 32'h8C22_0004, 32'hBFC0_0000, '0, 1'b0, 1'b0);
      idle(1'b0);
      // fill to full, overflow attempt, drain
      step(1'b0, 32'h0, 32'h0, '0, 1'b0, 1'b1);
      for (int k = 0; k < 5; k++)
         step(1'b1, 32'h2000_0000 + 32'(k), 32'h1000 + 32'(4*k),
              16'(k), 1'b0, 1'b0);
      for (int k = 0; k < 6; k++) idle(1'b1);
      // streaming across pointer wrap
      pc = 32'h0040_0000;
      for (int k = 0; k < 20; k++) begin
         step(1'b1, $urandom, pc, 16'($urandom), 1'b1, 1'b0);
         pc += 32'd4;
      end
      idle(1'b1);
      idle(1'b1);
      // flush with a simultaneous in_valid
      for (int k = 0; k < 3; k++)
         step(1'b1, $urandom, 32'h3000 + 32'(4*k), '0, 1'b0, 1'b0);
      step(1'b1, 32'hDEAD_BEEF, 32'h0000_DEAD, 16'hFFFF, 1'b0, 1'b1);
      idle(1'b1);
      idle(1'b1);
      // exception bundle behind two entries
      step(1'b1, 32'h0000_0001, 32'h5000, '0, 1'b0, 1'b0);
      step(1'b1, 32'h0000_0002, 32'h5004, '0, 1'b0, 1'b0);
      step(1'b1, 32'h0000_0003, 32'h5008, 16'hA5C3, 1'b0, 1'b0);
      for (int k = 0; k < 4; k++) idle(1'b1);
      // random traffic with occasional flush and reset
      for (int k = 0; k < 400; k++)
         step(1'($urandom_range(0, 3) != 0), $urandom, $urandom,
              16'($urandom), 1'($urandom_range(0, 2) != 0),
              1'($urandom_range(0, 20) == 0),
              1'($urandom_range(0, 80) == 0));
      for (int k = 0; k < 6; k++) idle(1'b1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end
endmodule
